// File: rtl/alu_issue_queue_pkg.sv
// Shared reservation-station definitions: default widths, flag/null constants
// and the packed-CDB slice helper used by the ALU, LSB and branch stations.
`ifndef RS_CDB_SLICE
`define RS_CDB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package alu_issue_queue_pkg;
  localparam int DEPTH_DEF     = 8;
  localparam int CDB_PORTS_DEF = 4;
  localparam int TAG_W_DEF     = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int OP_W_DEF      = 6;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  localparam logic [TAG_W_DEF-1:0]  NULL_TAG  = {TAG_W_DEF{1'b0}};
  localparam logic [DATA_W_DEF-1:0] NULL_DATA = {DATA_W_DEF{1'b0}};
endpackage

// File: rtl/rs_age_select.sv
// Oldest-first grant over a request vector using an age matrix
// (row i bit j set = entry i is older than entry j). Purely combinational.
module rs_age_select
  import alu_issue_queue_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic                any_grant
);

  // An entry wins when every other requester is younger than it.
  always_comb begin
    grant = {N{INVALID}};
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i] & ~|(req & ~age[i] & ~(N'(1) << i));
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds decoded ops, wakes operands from the CDB,
// and issues the oldest ready op through a registered valid/ready port.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CDB_PORTS = CDB_PORTS_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clear,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic                        disp_valid,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [DATA_W-1:0]           disp_imm,
  input  logic [DATA_W-1:0]           disp_pc,
  input  logic                        disp_v1,
  input  logic [DATA_W-1:0]           disp_d1,
  input  logic [TAG_W-1:0]            disp_t1,
  input  logic                        disp_v2,
  input  logic [DATA_W-1:0]           disp_d2,
  input  logic [TAG_W-1:0]            disp_t2,
  input  logic [TAG_W-1:0]            disp_dest,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [DATA_W-1:0]           iss_r1,
  output logic [DATA_W-1:0]           iss_r2,
  output logic [DATA_W-1:0]           iss_imm,
  output logic [DATA_W-1:0]           iss_pc,
  output logic [TAG_W-1:0]            iss_dest
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]            valid_r, v1_r, v2_r;
  logic [OP_W-1:0]             op_r   [DEPTH];
  logic [DATA_W-1:0]           imm_r  [DEPTH];
  logic [DATA_W-1:0]           pc_r   [DEPTH];
  logic [DATA_W-1:0]           d1_r   [DEPTH];
  logic [DATA_W-1:0]           d2_r   [DEPTH];
  logic [TAG_W-1:0]            t1_r   [DEPTH];
  logic [TAG_W-1:0]            t2_r   [DEPTH];
  logic [TAG_W-1:0]            dest_r [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_r;
  logic [CNT_W-1:0]            count_r;

  logic                        iss_valid_r;
  logic [OP_W-1:0]             iss_op_r;
  logic [DATA_W-1:0]           iss_r1_r, iss_r2_r, iss_imm_r, iss_pc_r;
  logic [TAG_W-1:0]            iss_dest_r;

  logic                        full_s, disp_acc_s, load_s, any_s;
  logic [DEPTH-1:0]            free_vec_s, free_oh_s, ready_s, grant_s, free_s;
  logic [DATA_W:0]             lk1_s [DEPTH];
  logic [DATA_W:0]             lk2_s [DEPTH];
  logic [DATA_W:0]             dlk1_s, dlk2_s;
  logic [OP_W-1:0]             sel_op_s;
  logic [DATA_W-1:0]           sel_r1_s, sel_r2_s, sel_imm_s, sel_pc_s;
  logic [TAG_W-1:0]            sel_dest_s;

  // Returns {hit, data} for a tag against all CDB ports; lowest port wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]            tag,
    input logic [CDB_PORTS-1:0]        vld,
    input logic [CDB_PORTS*TAG_W-1:0]  tags,
    input logic [CDB_PORTS*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = {(DATA_W+1){1'b0}};
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      res = (vld[p] && (`RS_CDB_SLICE(tags, p, TAG_W) == tag)) ?
            {VALID, `RS_CDB_SLICE(data, p, DATA_W)} : res;
    end
    return res;
  endfunction

  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign disp_acc_s = disp_valid & ~full_s;
  assign free_vec_s = ~valid_r;
  assign free_oh_s  = free_vec_s & (~free_vec_s + DEPTH'(1));
  assign ready_s    = valid_r & v1_r & v2_r;
  assign load_s     = (~iss_valid_r | iss_ready) & any_s;

  rs_age_select #(.N(DEPTH)) u_age_select (
    .req       (ready_s),
    .age       (age_r),
    .grant     (grant_s),
    .any_grant (any_s)
  );

  // Slot release, CDB matches and the one-hot payload mux of the granted entry.
  always_comb begin
    free_s     = load_s ? grant_s : {DEPTH{INVALID}};
    dlk1_s     = cdb_lookup(disp_t1, cdb_valid, cdb_tag, cdb_data);
    dlk2_s     = cdb_lookup(disp_t2, cdb_valid, cdb_tag, cdb_data);
    sel_op_s   = {OP_W{1'b0}};
    sel_r1_s   = {DATA_W{1'b0}};
    sel_r2_s   = {DATA_W{1'b0}};
    sel_imm_s  = {DATA_W{1'b0}};
    sel_pc_s   = {DATA_W{1'b0}};
    sel_dest_s = {TAG_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk1_s[i]   = cdb_lookup(t1_r[i], cdb_valid, cdb_tag, cdb_data);
      lk2_s[i]   = cdb_lookup(t2_r[i], cdb_valid, cdb_tag, cdb_data);
      sel_op_s   = sel_op_s   | ({OP_W{grant_s[i]}}   & op_r[i]);
      sel_r1_s   = sel_r1_s   | ({DATA_W{grant_s[i]}} & d1_r[i]);
      sel_r2_s   = sel_r2_s   | ({DATA_W{grant_s[i]}} & d2_r[i]);
      sel_imm_s  = sel_imm_s  | ({DATA_W{grant_s[i]}} & imm_r[i]);
      sel_pc_s   = sel_pc_s   | ({DATA_W{grant_s[i]}} & pc_r[i]);
      sel_dest_s = sel_dest_s | ({TAG_W{grant_s[i]}}  & dest_r[i]);
    end
  end

  // Entry storage, age matrix and occupancy count.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst || clear) begin
        valid_r <= {DEPTH{INVALID}};
        v1_r    <= {DEPTH{INVALID}};
        v2_r    <= {DEPTH{INVALID}};
        age_r   <= '0;
        count_r <= {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          op_r[i]   <= {OP_W{1'b0}};
          imm_r[i]  <= DATA_W'(NULL_DATA);
          pc_r[i]   <= DATA_W'(NULL_DATA);
          d1_r[i]   <= DATA_W'(NULL_DATA);
          d2_r[i]   <= DATA_W'(NULL_DATA);
          t1_r[i]   <= TAG_W'(NULL_TAG);
          t2_r[i]   <= TAG_W'(NULL_TAG);
          dest_r[i] <= TAG_W'(NULL_TAG);
        end
      end else begin
        count_r <= count_r + CNT_W'(disp_acc_s) - CNT_W'(load_s);
        for (int i = 0; i < DEPTH; i++) begin
          if (disp_acc_s && free_oh_s[i]) begin
            // New entry is the youngest: older than nobody.
            valid_r[i] <= VALID;
            op_r[i]    <= disp_op;
            imm_r[i]   <= disp_imm;
            pc_r[i]    <= disp_pc;
            dest_r[i]  <= disp_dest;
            t1_r[i]    <= disp_t1;
            t2_r[i]    <= disp_t2;
            v1_r[i]    <= disp_v1 | dlk1_s[DATA_W];
            v2_r[i]    <= disp_v2 | dlk2_s[DATA_W];
            d1_r[i]    <= disp_v1 ? disp_d1 : dlk1_s[DATA_W-1:0];
            d2_r[i]    <= disp_v2 ? disp_d2 : dlk2_s[DATA_W-1:0];
            age_r[i]   <= '0;
          end else begin
            if (free_s[i]) begin
              valid_r[i] <= INVALID;
            end
            if (valid_r[i] && !v1_r[i] && lk1_s[i][DATA_W]) begin
              v1_r[i] <= VALID;
              d1_r[i] <= lk1_s[i][DATA_W-1:0];
            end
            if (valid_r[i] && !v2_r[i] && lk2_s[i][DATA_W]) begin
              v2_r[i] <= VALID;
              d2_r[i] <= lk2_s[i][DATA_W-1:0];
            end
            age_r[i] <= age_r[i] | ({DEPTH{valid_r[i] & disp_acc_s}} & free_oh_s);
          end
        end
      end
    end
  end

  // Issue register: loads the granted entry, holds under back-pressure.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst || clear) begin
        iss_valid_r <= INVALID;
        iss_op_r    <= {OP_W{1'b0}};
        iss_r1_r    <= DATA_W'(NULL_DATA);
        iss_r2_r    <= DATA_W'(NULL_DATA);
        iss_imm_r   <= DATA_W'(NULL_DATA);
        iss_pc_r    <= DATA_W'(NULL_DATA);
        iss_dest_r  <= TAG_W'(NULL_TAG);
      end else if (load_s) begin
        iss_valid_r <= VALID;
        iss_op_r    <= sel_op_s;
        iss_r1_r    <= sel_r1_s;
        iss_r2_r    <= sel_r2_s;
        iss_imm_r   <= sel_imm_s;
        iss_pc_r    <= sel_pc_s;
        iss_dest_r  <= sel_dest_s;
      end else if (!iss_valid_r || iss_ready) begin
        iss_valid_r <= INVALID;
      end
    end
  end

  assign full      = full_s;
  assign count     = count_r;
  assign iss_valid = iss_valid_r;
  assign iss_op    = iss_op_r;
  assign iss_r1    = iss_r1_r;
  assign iss_r2    = iss_r2_r;
  assign iss_imm   = iss_imm_r;
  assign iss_pc    = iss_pc_r;
  assign iss_dest  = iss_dest_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic, every
// cycle compared against an age-ordered queue model of the station.
module tb_alu_issue_queue;
  localparam int DEPTH = 8, CDB_PORTS = 4, TAG_W = 4, DATA_W = 32, OP_W = 6;

  logic clk = 1'b0;
  logic rst, rdy, clear, disp_valid, disp_v1, disp_v2, iss_ready;
  logic [OP_W-1:0] disp_op;
  logic [DATA_W-1:0] disp_imm, disp_pc, disp_d1, disp_d2;
  logic [TAG_W-1:0] disp_t1, disp_t2, disp_dest;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0] cdb_data;
  logic full, iss_valid;
  logic [$clog2(DEPTH):0] count;
  logic [OP_W-1:0] iss_op;
  logic [DATA_W-1:0] iss_r1, iss_r2, iss_imm, iss_pc;
  logic [TAG_W-1:0] iss_dest;

  alu_issue_queue #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .TAG_W(TAG_W),
                    .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .full(full), .count(count),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_v1(disp_v1), .disp_d1(disp_d1), .disp_t1(disp_t1),
    .disp_v2(disp_v2), .disp_d2(disp_d2), .disp_t2(disp_t2), .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_r1(iss_r1),
    .iss_r2(iss_r2), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_dest(iss_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0] op; logic [DATA_W-1:0] imm, pc, d1, d2;
    logic v1, v2; logic [TAG_W-1:0] t1, t2, dest;
  } ent_t;

  ent_t mq[$];                    // model entries, oldest first
  logic m_iv = 1'b0;
  ent_t m_iss;
  logic [TAG_W-1:0] hs_q[$];      // dests seen on completed handshakes
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cdb_find(input logic [TAG_W-1:0] tag, output logic hit, output logic [DATA_W-1:0] data);
    hit = 1'b0; data = '0;
    for (int p = 0; p < CDB_PORTS; p++)
      if (!hit && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
        hit = 1'b1; data = cdb_data[p*DATA_W +: DATA_W];
      end
  endtask

  task automatic model_step();
    int idx; logic acc, hit; logic [DATA_W-1:0] d; ent_t e;
    if (!rdy) return;
    if (rst || clear) begin
      mq.delete(); m_iv = 1'b0;
      m_iss = '{default: '0};
      return;
    end
    acc = disp_valid && (mq.size() < DEPTH);
    idx = -1;
    for (int i = 0; i < mq.size(); i++) if (idx < 0 && mq[i].v1 && mq[i].v2) idx = i;
    if (!m_iv || iss_ready) begin
      m_iv = (idx >= 0);
      if (idx >= 0) m_iss = mq[idx];
    end else idx = -1;
    for (int i = 0; i < mq.size(); i++) begin
      cdb_find(mq[i].t1, hit, d); if (!mq[i].v1 && hit) begin mq[i].v1 = 1'b1; mq[i].d1 = d; end
      cdb_find(mq[i].t2, hit, d); if (!mq[i].v2 && hit) begin mq[i].v2 = 1'b1; mq[i].d2 = d; end
    end
    if (idx >= 0) mq.delete(idx);
    if (acc) begin
      e = '{op: disp_op, imm: disp_imm, pc: disp_pc, d1: disp_d1, d2: disp_d2, v1: disp_v1,
            v2: disp_v2, t1: disp_t1, t2: disp_t2, dest: disp_dest};
      cdb_find(disp_t1, hit, d); if (!disp_v1 && hit) begin e.v1 = 1'b1; e.d1 = d; end
      cdb_find(disp_t2, hit, d); if (!disp_v2 && hit) begin e.v2 = 1'b1; e.d2 = d; end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    if (iss_valid === 1'b1 && iss_ready && rdy) hs_q.push_back(iss_dest);
    @(posedge clk);
    model_step();
    #1;
    check("iss_valid", iss_valid, m_iv);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    if (m_iv) begin
      check("iss_op", iss_op, m_iss.op);
      check("iss_r1", iss_r1, m_iss.d1);
      check("iss_r2", iss_r2, m_iss.d2);
      check("iss_imm", iss_imm, m_iss.imm);
      check("iss_pc", iss_pc, m_iss.pc);
      check("iss_dest", iss_dest, m_iss.dest);
    end
  endtask

  task automatic idle();
    rst = 1'b0; clear = 1'b0; rdy = 1'b1; disp_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic disp(input logic v1, input logic [TAG_W-1:0] t1, input logic v2,
                      input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] dest);
    disp_valid = 1'b1; disp_v1 = v1; disp_t1 = t1; disp_v2 = v2; disp_t2 = t2;
    disp_dest = dest; disp_op = OP_W'($urandom);
    disp_d1 = $urandom; disp_d2 = $urandom; disp_imm = $urandom; disp_pc = $urandom;
  endtask

  task automatic bcast(input int port, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[port] = 1'b1; cdb_tag[port*TAG_W +: TAG_W] = tag; cdb_data[port*DATA_W +: DATA_W] = data;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    idle(); iss_ready = 1'b1; cdb_tag = '0; cdb_data = '0;
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd0); disp_valid = 1'b0;

    // Reset mid-operation
    do_reset();
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd9); tick();
    for (int k = 0; k < 3; k++) begin disp(1'b0, 4'd9, 1'b1, 4'd0, 4'(k)); tick(); end
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    check("rst_count", count, 0); check("rst_full", full, 0); check("rst_iss_valid", iss_valid, 0);
    check("rst_payload", {iss_op, iss_r1, iss_r2, iss_imm, iss_pc, iss_dest} == '0, 1);

    // Oldest-first with stall and late wakeup
    do_reset(); iss_ready = 1'b0;
    disp(1'b0, 4'd5, 1'b1, 4'd0, 4'd1); tick();
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd2); tick();
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd3); tick();
    idle(); tick(); tick();
    hs_q.delete(); iss_ready = 1'b1; bcast(0, 4'd5, 32'h0000_5555); tick();
    idle(); tick(); tick();
    check("order_n", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("order_0", hs_q[0], 4'd2); check("order_1", hs_q[1], 4'd3); check("order_2", hs_q[2], 4'd1);
    end

    // Same-cycle dispatch wakeup, lowest matching port wins
    do_reset();
    disp(1'b0, 4'd3, 1'b1, 4'd0, 4'd7);
    bcast(2, 4'd3, 32'hDEAD_BEEF); bcast(3, 4'd3, 32'h1234_5678); tick();
    idle(); tick();
    check("wake_valid", iss_valid, 1); check("wake_r1", iss_r1, 32'hDEAD_BEEF);

    // Full boundary
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin disp(1'b0, 4'(k), 1'b1, 4'd0, 4'(k)); tick(); end
    check("full_set", full, 1); check("full_count", count, DEPTH);
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd15); tick();
    check("full_drop", count, DEPTH);
    idle(); bcast(0, 4'd0, 32'hA); tick();
    idle(); tick();
    check("full_clear", full, 0); check("full_cnt7", count, DEPTH - 1);
    bcast(1, 4'd1, 32'hB); tick();
    idle(); disp(1'b0, 4'd15, 1'b1, 4'd0, 4'd14); tick();
    check("disp_iss_count", count, DEPTH - 1);

    // Back-pressure then full-rate drain
    do_reset(); iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin disp(1'b1, 4'd0, 1'b1, 4'd0, 4'(k + 8)); tick(); end
    idle();
    for (int k = 0; k < 4; k++) begin tick(); check("bp_count", count, 3); check("bp_dest", iss_dest, 4'd8); end
    hs_q.delete(); iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("bp_rate", hs_q.size(), 4);

    // Flush with a pending wakeup
    do_reset(); iss_ready = 1'b0;
    disp(1'b1, 4'd0, 1'b1, 4'd0, 4'd1); tick();
    disp(1'b0, 4'd6, 1'b1, 4'd0, 4'd2); tick();
    idle(); clear = 1'b1; bcast(0, 4'd6, 32'h66); tick();
    check("flush_count", count, 0); check("flush_valid", iss_valid, 0);
    idle(); iss_ready = 1'b1; bcast(0, 4'd6, 32'h66); tick();
    idle(); tick();
    check("flush_late", iss_valid, 0); check("flush_late_cnt", count, 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      clear = ($urandom_range(0, 99) == 0);
      iss_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        disp(1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
      else disp_valid = 1'b0;
      cdb_valid = CDB_PORTS'($urandom);
      for (int p = 0; p < CDB_PORTS; p++) begin
        cdb_tag[p*TAG_W +: TAG_W] = 4'($urandom_range(0, 7));
        cdb_data[p*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
